// File: rtl/i2c_pkg.sv
// Shared I2C definitions: sequencer state encoding, master rw encoding, bus timing
// constants and the read-length clamp used by i2c_reg_seq.
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } seq_state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam int unsigned I2C_SYS_CLK_HZ = 12_000_000;
    localparam int unsigned I2C_BUS_HZ     = 400_000;

    // A zero length still reads one byte; anything above max_rd is cut to max_rd.
    function automatic logic [2:0] clamp_rd_len(input logic [2:0] len, input int unsigned max_rd);
        if (len == 3'd0) return 3'd1;
        if ({29'd0, len} > max_rd) return 3'(max_rd);
        return len;
    endfunction

endpackage

// File: rtl/i2c_edge_det.sv
// Registers a level once per clock and reports its rising and falling edges.
module i2c_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_sig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sig_q <= 1'b0;
        else     r_sig_q <= i_sig;
    end

    assign o_rise = i_sig & ~r_sig_q;
    assign o_fall = ~i_sig & r_sig_q;

endmodule

// File: rtl/i2c_reg_seq.sv
// Register-access sequencer in front of i2c_master: turns one request into a register
// write or a repeated-start read burst, streaming read bytes out with a strobe.
module i2c_reg_seq
    import i2c_pkg::*;
#(
    parameter int unsigned MAX_RD      = 4,
    parameter int unsigned TIMEOUT_CYC = 2_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic       wr_mode,
    input  logic [7:0] wr_data,
    input  logic [2:0] rd_len,
    output logic       ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       done,
    output logic       error,
    output logic       i2c_enable,
    output logic [6:0] i2c_addr,
    output logic       i2c_rw,
    output logic [7:0] i2c_data_wr,
    input  logic       i2c_busy,
    input  logic       i2c_ack_err,
    input  logic [7:0] i2c_data_rd
);

    localparam int unsigned            WDOG_W    = $clog2(TIMEOUT_CYC);
    localparam logic [WDOG_W-1:0]      WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

    seq_state_t        r_state, w_state_nxt;
    logic              r_enable, w_enable_nxt;
    logic [6:0]        r_addr, w_addr_nxt;
    logic              r_rw, w_rw_nxt;
    logic [7:0]        r_data_wr, w_data_wr_nxt;
    logic              r_wr_mode, w_wr_mode_nxt;
    logic [7:0]        r_wr_data, w_wr_data_nxt;
    logic [2:0]        r_len, w_len_nxt;
    logic [3:0]        r_rise_cnt, w_rise_cnt_nxt;
    logic [WDOG_W-1:0] r_wdog, w_wdog_nxt;
    logic              r_error, w_error_nxt;
    logic [7:0]        r_rd_data, w_rd_data_nxt;
    logic              r_rd_valid, w_rd_valid_nxt;

    logic       w_rise, w_fall;
    logic [3:0] w_k;
    logic       w_rd_cap;
    logic       w_tmo;

    i2c_edge_det u_busy_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (i2c_busy),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_enable   <= 1'b0;
            r_addr     <= '0;
            r_rw       <= RW_WRITE;
            r_data_wr  <= '0;
            r_wr_mode  <= 1'b0;
            r_wr_data  <= '0;
            r_len      <= '0;
            r_rise_cnt <= '0;
            r_wdog     <= '0;
            r_error    <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_enable   <= w_enable_nxt;
            r_addr     <= w_addr_nxt;
            r_rw       <= w_rw_nxt;
            r_data_wr  <= w_data_wr_nxt;
            r_wr_mode  <= w_wr_mode_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_len      <= w_len_nxt;
            r_rise_cnt <= w_rise_cnt_nxt;
            r_wdog     <= w_wdog_nxt;
            r_error    <= w_error_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rd_valid <= w_rd_valid_nxt;
        end
    end

    // Byte k of a burst completes on the fall after rise k+1; the fall after the
    // register-pointer byte (rise_cnt<2) carries no read data.
    assign w_k      = r_rise_cnt + 4'd1;
    assign w_rd_cap = ~r_wr_mode & (r_rise_cnt >= 4'd2) & w_fall & ~i2c_ack_err & ~r_error;
    assign w_tmo    = (r_wdog == WDOG_LAST) & ~w_rise & ~w_fall;

    always_comb begin
        w_state_nxt    = r_state;
        w_enable_nxt   = r_enable;
        w_addr_nxt     = r_addr;
        w_rw_nxt       = r_rw;
        w_data_wr_nxt  = r_data_wr;
        w_wr_mode_nxt  = r_wr_mode;
        w_wr_data_nxt  = r_wr_data;
        w_len_nxt      = r_len;
        w_rise_cnt_nxt = r_rise_cnt;
        w_wdog_nxt     = '0;
        w_error_nxt    = r_error;
        w_rd_data_nxt  = r_rd_data;
        w_rd_valid_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_wr_mode_nxt  = wr_mode;
                    w_wr_data_nxt  = wr_data;
                    w_len_nxt      = clamp_rd_len(rd_len, MAX_RD);
                    w_error_nxt    = 1'b0;
                    w_enable_nxt   = 1'b1;
                    w_addr_nxt     = dev_addr;
                    w_rw_nxt       = RW_WRITE;
                    w_data_wr_nxt  = reg_addr;
                    w_rise_cnt_nxt = '0;
                    w_state_nxt    = ST_RUN;
                end
            end

            ST_RUN: begin
                w_wdog_nxt = (w_rise | w_fall) ? '0 : r_wdog + WDOG_W'(1);
                if (w_rise) w_rise_cnt_nxt = w_k;
                if (w_tmo) begin
                    w_error_nxt  = 1'b1;
                    w_enable_nxt = 1'b0;
                    w_wdog_nxt   = '0;
                    w_state_nxt  = ST_REPORT;
                end else if (w_fall && i2c_ack_err) begin
                    w_error_nxt  = 1'b1;
                    w_enable_nxt = 1'b0;
                    w_state_nxt  = ST_DRAIN;
                end else if (w_rise) begin
                    if (r_wr_mode) begin
                        if (w_k == 4'd1) begin
                            w_data_wr_nxt = r_wr_data;
                        end else if (w_k == 4'd2) begin
                            w_enable_nxt = 1'b0;
                            w_state_nxt  = ST_DRAIN;
                        end
                    end else begin
                        if (w_k == 4'd1) begin
                            w_rw_nxt = RW_READ;
                        end else if (w_k == ({1'b0, r_len} + 4'd1)) begin
                            w_enable_nxt = 1'b0;
                            w_state_nxt  = ST_DRAIN;
                        end
                    end
                end else if (w_rd_cap) begin
                    w_rd_data_nxt  = i2c_data_rd;
                    w_rd_valid_nxt = 1'b1;
                end
            end

            ST_DRAIN: begin
                w_wdog_nxt = (w_rise | w_fall) ? '0 : r_wdog + WDOG_W'(1);
                if (w_tmo) begin
                    w_error_nxt  = 1'b1;
                    w_enable_nxt = 1'b0;
                    w_wdog_nxt   = '0;
                    w_state_nxt  = ST_REPORT;
                end else if (w_fall) begin
                    if (w_rd_cap) begin
                        w_rd_data_nxt  = i2c_data_rd;
                        w_rd_valid_nxt = 1'b1;
                    end
                    w_state_nxt = ST_REPORT;
                end else if (!i2c_busy) begin
                    w_state_nxt = ST_REPORT;
                end
            end

            ST_REPORT: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ready       = (r_state == ST_IDLE);
    assign done        = (r_state == ST_REPORT);
    assign error       = r_error;
    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign i2c_enable  = r_enable;
    assign i2c_addr    = r_addr;
    assign i2c_rw      = r_rw;
    assign i2c_data_wr = r_data_wr;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Directed bench for i2c_reg_seq with a behavioural busy-handshake master and a slave
// at 0x50 whose read data is 11 22 33 44 ...; bus bytes are logged and compared.
module tb_i2c_reg_seq;

    localparam int BT      = 16;
    localparam int TMO     = 1000;
    localparam int B_S     = 256;
    localparam int B_SR    = 257;
    localparam int B_P     = 258;
    localparam logic [6:0] SLV_ADDR = 7'h50;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic       wr_mode;
    logic [7:0] wr_data;
    logic [2:0] rd_len;
    logic       ready, rd_valid, done, error;
    logic [7:0] rd_data;
    logic       i2c_enable, i2c_rw;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_data_wr;
    logic       m_busy, m_ack_err, m_hang, m_active;
    logic [7:0] m_data_rd;

    int         n_chk = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    logic       last_err;
    logic [7:0] rd_q[$];
    int         bus_log[$];
    logic [7:0] slv_mem[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    i2c_reg_seq #(.MAX_RD(4), .TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dev_addr    (dev_addr),
        .reg_addr    (reg_addr),
        .wr_mode     (wr_mode),
        .wr_data     (wr_data),
        .rd_len      (rd_len),
        .ready       (ready),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .done        (done),
        .error       (error),
        .i2c_enable  (i2c_enable),
        .i2c_addr    (i2c_addr),
        .i2c_rw      (i2c_rw),
        .i2c_data_wr (i2c_data_wr),
        .i2c_busy    (m_busy),
        .i2c_ack_err (m_ack_err),
        .i2c_data_rd (m_data_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid) rd_q.push_back(rd_data);
        if (done) begin
            done_cnt++;
            last_err = error;
        end
    end

    // Master model: busy rises when a command is latched and falls at each byte end;
    // enable is re-checked two cycles after the fall, a changed addr/rw means Sr.
    task automatic master_txn();
        logic [6:0] a;
        logic       rw;
        logic [7:0] d;
        int         idx;
        m_active  = 1'b1;
        m_ack_err = 1'b0;
        idx       = 0;
        a  = i2c_addr;
        rw = i2c_rw;
        d  = i2c_data_wr;
        m_busy = 1'b1;
        bus_log.push_back(B_S);
        bus_log.push_back(int'({a, rw}));
        if (m_hang) begin
            while (m_hang) @(negedge clk);
            m_busy   = 1'b0;
            m_active = 1'b0;
            return;
        end
        repeat (BT) @(negedge clk);
        forever begin
            if (a != SLV_ADDR) begin
                m_ack_err = 1'b1;
                m_busy    = 1'b0;
                bus_log.push_back(B_P);
                break;
            end
            if (rw) begin
                m_data_rd = slv_mem[idx];
                idx++;
                bus_log.push_back(int'(m_data_rd));
            end else begin
                bus_log.push_back(int'(d));
            end
            repeat (BT) @(negedge clk);
            m_busy = 1'b0;
            repeat (2) @(negedge clk);
            if (!i2c_enable) begin
                bus_log.push_back(B_P);
                break;
            end
            if (i2c_addr != a || i2c_rw != rw) begin
                a  = i2c_addr;
                rw = i2c_rw;
                d  = i2c_data_wr;
                m_busy = 1'b1;
                bus_log.push_back(B_SR);
                bus_log.push_back(int'({a, rw}));
                repeat (BT) @(negedge clk);
            end else begin
                d = i2c_data_wr;
                m_busy = 1'b1;
            end
        end
        m_active = 1'b0;
    endtask

    initial begin
        m_busy = 1'b0; m_ack_err = 1'b0; m_data_rd = '0; m_hang = 1'b0; m_active = 1'b0;
        forever begin
            @(negedge clk);
            if (i2c_enable) master_txn();
        end
    end

    task automatic do_req(input logic [6:0] a, input logic [7:0] r, input logic wm,
                          input logic [7:0] wd, input logic [2:0] len, input bit noisy,
                          output int cyc);
        @(negedge clk);
        bus_log.delete();
        rd_q.delete();
        done_cnt = 0;
        dev_addr = a; reg_addr = r; wr_mode = wm; wr_data = wd; rd_len = len;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        if (noisy) begin
            repeat (40) @(negedge clk);
            chk("ready_in_run", 32'(ready), 32'd0);
            dev_addr = 7'h51; wr_mode = 1'b1; rd_len = 3'd1; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc = 41;
        end
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        repeat (30) @(negedge clk);
        chk("done_once", 32'(done_cnt), 32'd1);
    endtask

    task automatic cmp_log(input string tag, input int exp[12], input int n);
        chk($sformatf("%s_len", tag), 32'(bus_log.size()), 32'(n));
        for (int i = 0; i < n; i++)
            if (i < bus_log.size()) chk($sformatf("%s[%0d]", tag, i), 32'(bus_log[i]), 32'(exp[i]));
    endtask

    task automatic cmp_rd(input string tag, input logic [7:0] exp[4], input int n);
        chk($sformatf("%s_cnt", tag), 32'(rd_q.size()), 32'(n));
        for (int i = 0; i < n; i++)
            if (i < rd_q.size()) chk($sformatf("%s[%0d]", tag, i), 32'(rd_q[i]), 32'(exp[i]));
    endtask

    initial begin
        int cyc;
        rst = 1'b1; start = 1'b0; dev_addr = '0; reg_addr = '0; wr_mode = 1'b0;
        wr_data = '0; rd_len = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready",   32'(ready),       32'd1);
        chk("rst_done",    32'(done),        32'd0);
        chk("rst_error",   32'(error),       32'd0);
        chk("rst_rdvalid", 32'(rd_valid),    32'd0);
        chk("rst_rddata",  32'(rd_data),     32'd0);
        chk("rst_enable",  32'(i2c_enable),  32'd0);
        chk("rst_rw",      32'(i2c_rw),      32'd0);
        chk("rst_addr",    32'(i2c_addr),    32'd0);
        chk("rst_datawr",  32'(i2c_data_wr), 32'd0);
        rst = 1'b0;

        do_req(7'h50, 8'h10, 1'b1, 8'hA5, 3'd0, 1'b0, cyc);
        cmp_log("wr_bus", '{B_S, 8'hA0, 8'h10, 8'hA5, B_P, 0, 0, 0, 0, 0, 0, 0}, 5);
        chk("wr_err", 32'(last_err), 32'd0);
        chk("wr_rdcnt", 32'(rd_q.size()), 32'd0);

        do_req(7'h50, 8'h02, 1'b0, 8'h00, 3'd3, 1'b1, cyc);
        cmp_log("rd3_bus", '{B_S, 8'hA0, 8'h02, B_SR, 8'hA1, 8'h11, 8'h22, 8'h33, B_P, 0, 0, 0}, 9);
        cmp_rd("rd3_data", '{8'h11, 8'h22, 8'h33, 8'h00}, 3);
        chk("rd3_err", 32'(last_err), 32'd0);
        repeat (20) @(negedge clk);
        chk("noisy_no_txn", 32'(bus_log.size()), 32'd9);

        do_req(7'h51, 8'h02, 1'b0, 8'h00, 3'd2, 1'b0, cyc);
        cmp_log("nack_bus", '{B_S, 8'hA2, B_P, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 3);
        chk("nack_err", 32'(last_err), 32'd1);
        chk("nack_rdcnt", 32'(rd_q.size()), 32'd0);

        do_req(7'h50, 8'h07, 1'b0, 8'h00, 3'd0, 1'b0, cyc);
        cmp_log("len0_bus", '{B_S, 8'hA0, 8'h07, B_SR, 8'hA1, 8'h11, B_P, 0, 0, 0, 0, 0}, 7);
        cmp_rd("len0_data", '{8'h11, 8'h00, 8'h00, 8'h00}, 1);
        chk("len0_err", 32'(last_err), 32'd0);

        do_req(7'h50, 8'h08, 1'b0, 8'h00, 3'd7, 1'b0, cyc);
        cmp_log("len7_bus", '{B_S, 8'hA0, 8'h08, B_SR, 8'hA1, 8'h11, 8'h22, 8'h33, 8'h44, B_P, 0, 0}, 10);
        cmp_rd("len7_data", '{8'h11, 8'h22, 8'h33, 8'h44}, 4);

        m_hang = 1'b1;
        do_req(7'h50, 8'h05, 1'b0, 8'h00, 3'd1, 1'b0, cyc);
        chk("tmo_window", 32'(cyc >= TMO - 1 && cyc <= TMO + 3), 32'd1);
        chk("tmo_err", 32'(last_err), 32'd1);
        chk("tmo_rdcnt", 32'(rd_q.size()), 32'd0);
        chk("tmo_enable", 32'(i2c_enable), 32'd0);
        m_hang = 1'b0;
        repeat (5) @(negedge clk);

        @(negedge clk);
        rd_q.delete();
        done_cnt = 0;
        dev_addr = 7'h50; reg_addr = 8'h03; wr_mode = 1'b0; rd_len = 3'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (rd_q.size() < 1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid_byte1", 32'(rd_q.size()), 32'd1);
        chk("rst_mid_enable_pre", 32'(i2c_enable), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_enable", 32'(i2c_enable), 32'd0);
        chk("rst_mid_ready", 32'(ready), 32'd1);
        repeat (100) @(negedge clk);
        chk("rst_mid_nodone", 32'(done_cnt), 32'd0);
        chk("rst_mid_master_idle", 32'(m_active), 32'd0);
        rst = 1'b0;

        do_req(7'h50, 8'h20, 1'b1, 8'h5A, 3'd0, 1'b0, cyc);
        cmp_log("wr2_bus", '{B_S, 8'hA0, 8'h20, 8'h5A, B_P, 0, 0, 0, 0, 0, 0, 0}, 5);
        chk("wr2_err", 32'(last_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
